// File: rtl/fp16_systolic_array_3x3.sv
// FP16 diagonal-flow systolic multiply-accumulate grid (5x5 cells).
// A moves east along rows, B moves south along columns, and each cell's
// partial sum moves diagonally to the cell one row down and one column right.
// Skew-feeding three A rows and three B columns on the boundary yields a
// 3x3 matrix product on the south-east corner outputs.
// Arithmetic is a reduced FP16: subnormals flush to zero, every step
// truncates, overflow saturates to max finite, and exponent 31 is treated
// as an ordinary exponent.
module fp16_systolic_array_3x3 #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  // A operands entering column 0 of each row
  input  logic [DATA_W-1:0] a00,
  input  logic [DATA_W-1:0] a10,
  input  logic [DATA_W-1:0] a20,
  input  logic [DATA_W-1:0] a30,
  input  logic [DATA_W-1:0] a40,
  // B operands entering row 0 of each column
  input  logic [DATA_W-1:0] b00,
  input  logic [DATA_W-1:0] b01,
  input  logic [DATA_W-1:0] b02,
  input  logic [DATA_W-1:0] b03,
  input  logic [DATA_W-1:0] b04,
  // Partial sums entering the north and west edges
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c02,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c20,
  // A leaving the east edge
  output logic [DATA_W-1:0] a05,
  output logic [DATA_W-1:0] a15,
  output logic [DATA_W-1:0] a25,
  output logic [DATA_W-1:0] a35,
  output logic [DATA_W-1:0] a45,
  // B leaving the south edge
  output logic [DATA_W-1:0] b50,
  output logic [DATA_W-1:0] b51,
  output logic [DATA_W-1:0] b52,
  output logic [DATA_W-1:0] b53,
  output logic [DATA_W-1:0] b54,
  // Partial sums leaving the south and east edges
  output logic [DATA_W-1:0] c53,
  output logic [DATA_W-1:0] c54,
  output logic [DATA_W-1:0] c55,
  output logic [DATA_W-1:0] c35,
  output logic [DATA_W-1:0] c45
);

  localparam int          N        = 5;
  localparam logic [14:0] MAX_MAG  = 15'h7BFF;  // exponent 30, all-ones fraction
  localparam logic [15:0] FP_ZERO  = 16'h0000;

  // ---------------------------------------------------------------------------
  // FP16 multiply: hidden-one significands, one-step normalize, truncate.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] fp_mul(input logic [15:0] x, input logic [15:0] y);
    logic              sign;
    logic [21:0]       prod;
    logic signed [7:0] exp_r;
    logic [9:0]        frac;
    logic [15:0]       res;
    sign  = x[15] ^ y[15];
    prod  = {11'd0, 1'b1, x[9:0]} * {11'd0, 1'b1, y[9:0]};
    exp_r = $signed({3'b000, x[14:10]}) + $signed({3'b000, y[14:10]}) - 8'sd15;
    // Product of two [1,2) significands lies in [1,4): at most one shift.
    if (prod[21]) begin
      frac  = prod[20:11];
      exp_r = exp_r + 8'sd1;
    end else begin
      frac  = prod[19:10];
    end
    if (x[14:10] == 5'd0 || y[14:10] == 5'd0) begin
      res = FP_ZERO;
    end else if (exp_r < 8'sd1) begin
      res = FP_ZERO;
    end else if (exp_r > 8'sd30) begin
      res = {sign, MAX_MAG};
    end else begin
      res = {sign, exp_r[4:0], frac};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // FP16 add: align the smaller magnitude (bits shifted out are lost),
  // add or subtract, renormalize around the leading one, truncate.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0]       big;
    logic [15:0]       sml;
    logic [4:0]        shift;
    logic [11:0]       m_big;
    logic [11:0]       m_sml;
    logic [11:0]       r;
    logic [11:0]       norm;
    logic [3:0]        msb;
    logic signed [7:0] exp_r;
    logic [9:0]        frac;
    logic [15:0]       res;
    // NOTE: every local gets a value on every path before it is read, so
    // the combinational cone built from this function never holds state.
    norm = '0;
    // For normal numbers {exponent, fraction} orders by magnitude.
    if (x[14:0] >= y[14:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    shift = big[14:10] - sml[14:10];
    m_big = {1'b0, 1'b1, big[9:0]};
    m_sml = {1'b0, 1'b1, sml[9:0]} >> shift;
    if (big[15] == sml[15]) begin
      r = m_big + m_sml;
    end else begin
      r = m_big - m_sml;  // never negative: big has the larger magnitude
    end
    // Leading-one detect; bit 11 is a carry out of the addition.
    msb = 4'd0;
    for (int k = 0; k < 12; k++) begin
      if (r[k]) msb = 4'(k);
    end
    exp_r = $signed({3'b000, big[14:10]}) + $signed({4'b0000, msb}) - 8'sd10;
    if (msb == 4'd11) begin
      frac = r[10:1];
    end else begin
      norm = r << (4'd10 - msb);
      frac = norm[9:0];
    end
    if (x[14:10] == 5'd0 && y[14:10] == 5'd0) begin
      res = FP_ZERO;
    end else if (x[14:10] == 5'd0) begin
      res = y;
    end else if (y[14:10] == 5'd0) begin
      res = x;
    end else if (r == 12'd0) begin
      res = FP_ZERO;  // exact cancellation
    end else if (exp_r < 8'sd1) begin
      res = FP_ZERO;
    end else if (exp_r > 8'sd30) begin
      res = {big[15], MAX_MAG};
    end else begin
      res = {big[15], exp_r[4:0], frac};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Grid state: one A, B and C register per cell.
  // ---------------------------------------------------------------------------
  logic [15:0] a_q [N][N];
  logic [15:0] b_q [N][N];
  logic [15:0] c_q [N][N];
  logic [15:0] a_d [N][N];
  logic [15:0] b_d [N][N];
  logic [15:0] c_d [N][N];

  // Boundary feeds; cells without a partial-sum port start from +0.
  logic [15:0] a_west  [N];
  logic [15:0] b_north [N];
  logic [15:0] c_north [N];
  logic [15:0] c_west  [1:N-1];

  assign a_west[0]  = a00;
  assign a_west[1]  = a10;
  assign a_west[2]  = a20;
  assign a_west[3]  = a30;
  assign a_west[4]  = a40;

  assign b_north[0] = b00;
  assign b_north[1] = b01;
  assign b_north[2] = b02;
  assign b_north[3] = b03;
  assign b_north[4] = b04;

  assign c_north[0] = c00;
  assign c_north[1] = c01;
  assign c_north[2] = c02;
  assign c_north[3] = FP_ZERO;
  assign c_north[4] = FP_ZERO;

  assign c_west[1]  = c10;
  assign c_west[2]  = c20;
  assign c_west[3]  = FP_ZERO;
  assign c_west[4]  = FP_ZERO;

  // Per-cell wiring and MAC datapath.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [15:0] a_in;
      logic [15:0] b_in;
      logic [15:0] c_in;
      logic [15:0] prod;

      if (gj == 0) begin : g_a_edge
        assign a_in = a_west[gi];
      end else begin : g_a_inner
        assign a_in = a_q[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in = b_north[gj];
      end else begin : g_b_inner
        assign b_in = b_q[gi-1][gj];
      end

      if (gi == 0) begin : g_c_north
        assign c_in = c_north[gj];
      end else if (gj == 0) begin : g_c_west
        assign c_in = c_west[gi];
      end else begin : g_c_diag
        assign c_in = c_q[gi-1][gj-1];
      end

      assign prod        = fp_mul(a_in, b_in);
      assign a_d[gi][gj] = a_in;
      assign b_d[gi][gj] = b_in;
      assign c_d[gi][gj] = fp_add(c_in, prod);
    end
  end

  // Advance every cell each edge; reset clears the whole grid and wins over data.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the grid is plain pipeline flops rather than a RAM, so every
      // element is cleared; reset must flush in-flight partial sums.
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j] <= FP_ZERO;
          b_q[i][j] <= FP_ZERO;
          c_q[i][j] <= FP_ZERO;
        end
      end
    end else begin
      // NOTE: non-blocking updates make every cell sample its neighbour's
      // previous value, which is what moves data one cell per edge.
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  // Corner cells whose partial sums run off the grid without an output port.
  logic unused_c_tail;
  assign unused_c_tail = ^{c_q[0][4], c_q[1][4], c_q[4][0], c_q[4][1]};

  assign a05 = a_q[0][4];
  assign a15 = a_q[1][4];
  assign a25 = a_q[2][4];
  assign a35 = a_q[3][4];
  assign a45 = a_q[4][4];

  assign b50 = b_q[4][0];
  assign b51 = b_q[4][1];
  assign b52 = b_q[4][2];
  assign b53 = b_q[4][3];
  assign b54 = b_q[4][4];

  assign c53 = c_q[4][2];
  assign c54 = c_q[4][3];
  assign c55 = c_q[4][4];
  assign c35 = c_q[2][4];
  assign c45 = c_q[3][4];

endmodule

// File: tb/tb_fp16_systolic_array_3x3.sv
// Self-checking bench for fp16_systolic_array_3x3: expected outputs are
// queued with their due cycle when stimulus is applied and compared when
// that cycle's outputs are sampled (1 time unit after the rising edge).
module tb_fp16_systolic_array_3x3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a_drv [5];
  logic [15:0] b_drv [5];
  logic [15:0] c_drv [5];    // c00, c01, c02, c10, c20
  logic [15:0] dut_out [15]; // a05..a45, b50..b54, c53, c54, c55, c35, c45

  localparam int IDX_A25 = 2;
  localparam int IDX_C53 = 10;
  localparam int IDX_C54 = 11;
  localparam int IDX_C55 = 12;
  localparam int IDX_C35 = 13;
  localparam int IDX_C45 = 14;

  string out_name [15] = '{"a05", "a15", "a25", "a35", "a45",
                           "b50", "b51", "b52", "b53", "b54",
                           "c53", "c54", "c55", "c35", "c45"};

  typedef struct {
    int          due;
    int          idx;
    logic [15:0] exp_bits;
    bit          approx;
    real         exp_real;
  } sb_entry_t;

  sb_entry_t sb [$];
  int        cyc      = 0;
  int        n_checks = 0;
  int        n_pass   = 0;

  always #5 clock = ~clock;

  fp16_systolic_array_3x3 #(.DATA_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .a00   (a_drv[0]),
    .a10   (a_drv[1]),
    .a20   (a_drv[2]),
    .a30   (a_drv[3]),
    .a40   (a_drv[4]),
    .b00   (b_drv[0]),
    .b01   (b_drv[1]),
    .b02   (b_drv[2]),
    .b03   (b_drv[3]),
    .b04   (b_drv[4]),
    .c00   (c_drv[0]),
    .c01   (c_drv[1]),
    .c02   (c_drv[2]),
    .c10   (c_drv[3]),
    .c20   (c_drv[4]),
    .a05   (dut_out[0]),
    .a15   (dut_out[1]),
    .a25   (dut_out[2]),
    .a35   (dut_out[3]),
    .a45   (dut_out[4]),
    .b50   (dut_out[5]),
    .b51   (dut_out[6]),
    .b52   (dut_out[7]),
    .b53   (dut_out[8]),
    .b54   (dut_out[9]),
    .c53   (dut_out[10]),
    .c54   (dut_out[11]),
    .c55   (dut_out[12]),
    .c35   (dut_out[13]),
    .c45   (dut_out[14])
  );

  // Back-to-back arithmetic cases on the c00 -> c55 diagonal: a00, b00, c00 -> c55.
  localparam int NARITH = 13;
  localparam logic [15:0] AR_A [NARITH] = '{16'h3C00, 16'h4000, 16'h7BFF, 16'hFBFF, 16'h3C00,
                                           16'h3C00, 16'h3C00, 16'h0400, 16'h0001, 16'h3E00,
                                           16'h3C00, 16'h3C01, 16'h7BFF};
  localparam logic [15:0] AR_B [NARITH] = '{16'h4000, 16'hBC00, 16'h7BFF, 16'h7BFF, 16'h3E00,
                                           16'h1400, 16'h1000, 16'h0400, 16'h3C00, 16'h3E00,
                                           16'h3C00, 16'hBC00, 16'h3C00};
  localparam logic [15:0] AR_C [NARITH] = '{16'h3C00, 16'h4000, 16'h0000, 16'h0000, 16'hC400,
                                           16'h3C00, 16'h3C00, 16'h0000, 16'h4000, 16'h0000,
                                           16'h3C00, 16'h3C00, 16'h7BFF};
  // 1+2=3, 2-2=0, +sat, -sat, 1.5-4=-2.5, 1+2^-10, 1+2^-11 lost, underflow,
  // subnormal flush, 1.5*1.5=2.25, 1+1=2, 1-1.000977=-2^-10, add overflow
  localparam logic [15:0] AR_E [NARITH] = '{16'h4200, 16'h0000, 16'h7BFF, 16'hFBFF, 16'hC100,
                                           16'h3C01, 16'h3C00, 16'h0000, 16'h4000, 16'h4080,
                                           16'h4000, 16'h9400, 16'h7BFF};

  // Matrix operands as FP16 bit patterns, [row][col].
  localparam logic [15:0] MA [3][3] = '{'{16'h4640, 16'h405C, 16'h42CC},
                                       '{16'hC44D, 16'h3C66, 16'h4580},
                                       '{16'h4856, 16'hC89A, 16'h0000}};
  localparam logic [15:0] MB [3][3] = '{'{16'h3A00, 16'h4A00, 16'h4200},
                                       '{16'h4A2B, 16'h0000, 16'hC75C},
                                       '{16'h480F, 16'h46F1, 16'h4000}};

  function automatic real fp16_to_real(input logic [15:0] h);
    real v;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(int'(h[9:0])) / 1024.0;
    for (int k = 15; k < e; k++) v = v * 2.0;
    for (int k = e; k < 15; k++) v = v / 2.0;
    return h[15] ? -v : v;
  endfunction

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic zero_inputs();
    for (int i = 0; i < 5; i++) begin
      a_drv[i] = 16'h0000;
      b_drv[i] = 16'h0000;
      c_drv[i] = 16'h0000;
    end
  endtask

  task automatic expect_bits(input int lat, input int idx, input logic [15:0] v);
    sb_entry_t e;
    e.due      = cyc + lat;
    e.idx      = idx;
    e.exp_bits = v;
    e.approx   = 1'b0;
    e.exp_real = 0.0;
    sb.push_back(e);
  endtask

  task automatic expect_real(input int lat, input int idx, input real v);
    sb_entry_t e;
    e.due      = cyc + lat;
    e.idx      = idx;
    e.exp_bits = 16'h0000;
    e.approx   = 1'b1;
    e.exp_real = v;
    sb.push_back(e);
  endtask

  // Pop every entry due this cycle and compare it with the sampled output.
  task automatic drain();
    sb_entry_t e;
    real       got;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.due != cyc) begin
        $display("FAIL %s: entry due at cycle %0d reached only at cycle %0d",
                 out_name[e.idx], e.due, cyc);
      end else if (e.approx) begin
        got = fp16_to_real(dut_out[e.idx]);
        if (rabs(got - e.exp_real) > 0.01 * rabs(e.exp_real)) begin
          $display("FAIL %s: got %f (%h) expected %f within 1%% at cycle %0d",
                   out_name[e.idx], got, dut_out[e.idx], e.exp_real, cyc);
        end else begin
          n_pass++;
        end
      end else if (dut_out[e.idx] !== e.exp_bits) begin
        $display("FAIL %s: got %h expected %h at cycle %0d",
                 out_name[e.idx], dut_out[e.idx], e.exp_bits, cyc);
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
      drain();
    end
  endtask

  task automatic test_reset();
    // Fill the grid with nonzero data, then reset while inputs stay nonzero.
    for (int i = 0; i < 5; i++) begin
      a_drv[i] = 16'h3C00 + 16'(i);
      b_drv[i] = 16'h4000 + 16'(i);
      c_drv[i] = 16'h3800;
    end
    reset = 1'b0;
    step(6);
    reset = 1'b1;
    step(1);
    for (int k = 0; k < 15; k++) begin
      n_checks++;
      if (dut_out[k] !== 16'h0000) begin
        $display("FAIL reset_%s: got %h expected 0000", out_name[k], dut_out[k]);
      end else begin
        n_pass++;
      end
    end
    reset = 1'b0;
    zero_inputs();
    for (int c = 0; c < 5; c++) begin
      step(1);
      for (int k = 0; k < 15; k++) begin
        n_checks++;
        if (dut_out[k] !== 16'h0000) begin
          $display("FAIL hold_zero_%s: got %h expected 0000 at cycle %0d",
                   out_name[k], dut_out[k], cyc);
        end else begin
          n_pass++;
        end
      end
    end
  endtask

  task automatic test_passthrough();
    // Single A word: appears on a25 exactly 5 edges later, product with b=0 is zero.
    zero_inputs();
    a_drv[2] = 16'h3C00;
    expect_bits(4, IDX_A25, 16'h0000);
    expect_bits(5, IDX_A25, 16'h3C00);
    expect_bits(5, IDX_C55, 16'h0000);
    expect_bits(6, IDX_A25, 16'h0000);
    step(1);
    zero_inputs();
    step(6);
    // Random words on every A and B input for several consecutive edges.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 5; i++) begin
        a_drv[i] = 16'($urandom);
        b_drv[i] = 16'($urandom);
      end
      for (int i = 0; i < 5; i++) expect_bits(5, i, a_drv[i]);
      for (int j = 0; j < 5; j++) expect_bits(5, 5 + j, b_drv[j]);
      step(1);
    end
    zero_inputs();
    step(7);
  endtask

  task automatic test_c_ports();
    // Partial sums ride the diagonals unchanged when every product is zero.
    zero_inputs();
    c_drv[1] = 16'h4500;  // c01 -> c45
    c_drv[2] = 16'h3555;  // c02 -> c35
    c_drv[3] = 16'hC500;  // c10 -> c54
    c_drv[4] = 16'h7000;  // c20 -> c53
    expect_bits(2, IDX_C35, 16'h0000);
    expect_bits(2, IDX_C53, 16'h0000);
    expect_bits(3, IDX_C35, 16'h3555);
    expect_bits(3, IDX_C53, 16'h7000);
    expect_bits(4, IDX_C45, 16'h4500);
    expect_bits(4, IDX_C54, 16'hC500);
    step(1);
    zero_inputs();
    step(6);
  endtask

  task automatic test_back_to_back();
    // One arithmetic case per edge on PE(0,0); each lands on c55 five edges later.
    for (int k = 0; k < NARITH; k++) begin
      zero_inputs();
      a_drv[0] = AR_A[k];
      b_drv[0] = AR_B[k];
      c_drv[0] = AR_C[k];
      expect_bits(5, IDX_C55, AR_E[k]);
      step(1);
    end
    zero_inputs();
    step(6);
  endtask

  task automatic test_matrix();
    zero_inputs();
    expect_real(5, IDX_C55,   59.197);  // C00
    expect_real(5, IDX_C45,   98.596);  // C01
    expect_real(5, IDX_C35,    9.505);  // C02
    expect_real(5, IDX_C54,   54.997);  // C10
    expect_real(5, IDX_C53, -107.03);   // C20
    expect_real(6, IDX_C55,  -13.43);   // C11
    expect_real(6, IDX_C45,   -9.989);  // C12
    expect_real(6, IDX_C54,  104.04);   // C21
    expect_real(7, IDX_C55,   93.72);   // C22
    for (int k = 0; k < 3; k++) begin
      zero_inputs();
      for (int m = 0; m < 3; m++) begin
        a_drv[k + m] = MA[k][m];
        b_drv[k + m] = MB[m][k];
      end
      step(1);
    end
    zero_inputs();
    step(7);
  endtask

  task automatic test_reset_midflight();
    // Launch a MAC and an A word, then reset while both are in the grid.
    zero_inputs();
    a_drv[0] = 16'h3C00;
    b_drv[0] = 16'h4000;
    c_drv[0] = 16'h3C00;
    a_drv[2] = 16'h3C00;
    expect_bits(5, IDX_A25, 16'h0000);
    expect_bits(5, IDX_C55, 16'h0000);
    step(1);
    zero_inputs();
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    zero_inputs();
    reset = 1'b1;
    step(3);
    test_reset();
    test_passthrough();
    test_c_ports();
    test_back_to_back();
    test_matrix();
    test_reset_midflight();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d queued outputs never compared", sb.size());
      n_checks += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
